// File: rtl/dmem_stage.sv
// dmem_stage: handshaked Y86-64 data-memory stage.
// Decodes the icode when a request is accepted, commits stores on the
// acceptance edge, and returns load data after READ_LAT cycles. Any
// non-AOK status parks the stage in HALTED until reset.
module dmem_stage #(
   parameter int DEPTH       = 1024,
   parameter int READ_LAT    = 1,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   input  logic        instr_valid,
   input  logic        imem_error,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] valM,
   output logic        mem_error,
   output logic [2:0]  stat
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] LIMIT    = 64'(DEPTH) << 3;
   localparam logic [2:0]  LAST_CNT = 3'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd2;
   localparam logic [2:0] STAT_INS = 3'd3;
   localparam logic [2:0] STAT_HLT = 3'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      DONE   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t state, next_state;
   logic [2:0] cnt, cnt_next;

   logic [63:0] mem [DEPTH];

   // Request decode signals (valid whenever a request is presented)
   logic          is_read;
   logic          is_write;
   logic [63:0]   addr;
   logic [63:0]   wdata;
   logic          addr_err;
   logic          access_ok;
   logic [AW-1:0] idx;
   logic [2:0]    stat_d;
   logic [63:0]   rdata;
   logic          accept;

   // Captured result, held stable through BUSY and DONE
   logic [63:0] valm_p1;
   logic        mem_error_p1;
   logic [2:0]  stat_p1;

   // mrmovq, popq and ret load from memory
   function automatic logic read_op(input logic [3:0] ic);
      return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
   endfunction

   // rmmovq, pushq and call store to memory
   function automatic logic write_op(input logic [3:0] ic);
      return (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
   endfunction

   // popq and ret address through the stack pointer carried in valA
   function automatic logic addr_from_vala(input logic [3:0] ic);
      return (ic == 4'h9) || (ic == 4'hB);
   endfunction

   // Address, data, error and status decode for the presented request
   always_comb begin
      is_read   = read_op(icode);
      is_write  = write_op(icode);
      addr      = addr_from_vala(icode) ? valA : valE;
      wdata     = (icode == 4'h8) ? valP : valA;
      addr_err  = (is_read || is_write) &&
                  ((addr >= LIMIT) || (CHECK_ALIGN && (addr[2:0] != 3'b000)));
      access_ok = !addr_err && !imem_error && instr_valid;
      idx       = addr[AW+2:3];
      if (addr_err || imem_error)
         stat_d = STAT_ADR;
      else if (!instr_valid)
         stat_d = STAT_INS;
      else if (icode == 4'h0)
         stat_d = STAT_HLT;
      else
         stat_d = STAT_AOK;
      rdata = (is_read && access_ok) ? mem[idx] : 64'd0;
   end

   assign accept    = (state == IDLE) && in_valid;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   assign valM      = valm_p1;
   assign mem_error = mem_error_p1;
   assign stat      = stat_p1;

   // Store commit on the acceptance edge; array contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && accept && is_write && access_ok)
         mem[idx] <= wdata;
   end

   // ---- stage boundary: acceptance -> captured result ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valm_p1      <= 64'd0;
         mem_error_p1 <= 1'b0;
         stat_p1      <= STAT_AOK;
      end else if (accept) begin
         valm_p1      <= rdata;
         mem_error_p1 <= addr_err;
         stat_p1      <= stat_d;
      end
   end

   // State and latency-counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: only performed reads with READ_LAT>1 pass through BUSY
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               cnt_next = 3'd0;
               if (is_read && access_ok && (READ_LAT > 1))
                  next_state = BUSY;
               else
                  next_state = DONE;
            end
         end
         BUSY: begin
            if (cnt == LAST_CNT) begin
               cnt_next   = 3'd0;
               next_state = DONE;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         DONE: begin
            if (out_ready)
               next_state = (stat_p1 != STAT_AOK) ? HALTED : IDLE;
         end
         HALTED: begin
            next_state = HALTED;
         end
         default: begin
            next_state = IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parameterised, handshaked data-memory stage for the Y86-64 SEQ/pipelined datapath. It sits between execute and write-back and performs the icode-driven load/store for mrmovq, rmmovq, pushq, popq, call and ret against an internal word array with configurable depth and read latency. It reports the instruction status code (AOK/ADR/INS/HLT) alongside valM. After any non-AOK result it stops accepting requests until reset.

## Interface
- DEPTH, 1024: number of 64-bit words; legal byte addresses 0 .. DEPTH*8-1
- READ_LAT, 1: cycles from request acceptance to read result valid, legal 1..4
- CHECK_ALIGN, 1: when 1, addresses with addr[2:0]!=0 raise ADR
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request
- icode  in  4  instruction code
- valE, valA, valP  in  64 each  execute result, rA value, next PC
- instr_valid  in  1  decode found a valid instruction
- imem_error  in  1  fetch address error
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- valM  out  64  read data; 0 for non-reads and errored accesses
- mem_error  out  1  data-address error for this result
- stat  out  3  1=AOK, 2=ADR, 3=INS, 4=HLT

## Operation
- Decode on acceptance:
  - Reads: icode 5 (addr=valE), 9 and B (addr=valA).
  - Writes: icode 4 and A (addr=valE, data=valA); icode 8 (addr=valE, data=valP).
  - All other icodes perform no access.
- Address is a byte address; word index = addr>>3.
- mem_error=1 when the access is a read or write and either:
  - addr >= DEPTH*8 (unsigned, full 64-bit compare), or
  - CHECK_ALIGN=1 and addr[2:0]!=0.
- stat priority: (mem_error|imem_error)→2, else !instr_valid→3, else icode==0→4, else 1.
- Write commit: the array is written on the acceptance edge, only if the access is a write, mem_error=0, imem_error=0 and instr_valid=1.
- Read: a read is performed only under the same conditions; valM=0 otherwise.
- FSM states:
  - IDLE: in_ready=1. On in_valid, accept the request. A read with READ_LAT>1 goes to BUSY; every other request goes to DONE.
  - BUSY: a counter counts READ_LAT-1 further cycles, then the FSM goes to DONE.
  - DONE: out_valid=1; valM, stat and mem_error are held stable. On out_ready the FSM goes to HALTED if stat!=1, else to IDLE.
  - HALTED: in_ready=0 and out_valid=0 permanently until reset.
- in_ready is combinational from state only; it is never asserted in BUSY, DONE or HALTED. The stage holds at most one outstanding request.
- Array contents are not cleared by reset; they initialise to zero at simulation start.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, in_ready=1, out_valid=0, valM=0, mem_error=0, stat=1, latency counter=0.
  - Reset mid-operation discards any pending read. A write committed before reset stays in the array.
- Latency from acceptance edge to out_valid high: writes, non-memory ops and errored accesses take 1 cycle; reads take READ_LAT cycles.
- Back-to-back throughput: out_ready held high gives one request every 2 cycles for READ_LAT=1.
- Read-after-write: a read accepted after a write to the same word returns the new data.
- Backpressure: with out_ready=0 in DONE, outputs stay frozen indefinitely.
- out_valid/out_ready handshake completes on the edge where both are 1.

## Test plan
- Write then read, addr 0x40: rmmovq (icode 4, valE=0x40, valA=0xDEADBEEF), then mrmovq (icode 5, valE=0x40). Required: valM=0xDEADBEEF, stat=1, with READ_LAT=3 out_valid rises exactly 3 cycles after acceptance.
- call then ret: call (icode 8, valE=0x1F8, valP=0x123) then ret (icode 9, valA=0x1F8). Required: valM=0x123, stat=1 for both.
- Out of range with DEPTH=1024: read at 0x2000. Required: mem_error=1, stat=2, valM=0, then in_ready stays 0 after the handshake until rst_n pulses low.
- Misaligned write, CHECK_ALIGN=1: write at 0x41, then read 0x40. Required: first result stat=2, array unchanged after reset (read of 0x40 returns its old value).
- Status priority: instr_valid=0 gives stat=3; halt (icode 0) gives stat=4 and then HALTED; imem_error=1 together with instr_valid=0 gives stat=2.
- Backpressure and reset: hold out_ready=0 for 5 cycles with a read result pending; outputs must stay constant. Assert rst_n=0 mid-BUSY; out_valid must drop immediately and in_ready must return to 1.
